// File: rtl/sprite_table_pkg.sv
// Shared constants, types and helpers for the double-buffered sprite attribute table.
package sprite_table_pkg;

  localparam int NUM_SPRITES = 16;
  localparam int COORD_W     = 10;
  localparam int ID_W        = 4;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;

  localparam logic [ID_W-1:0] EMPTY_ID = 4'hF;

  typedef struct packed {
    logic [COORD_W-1:0] posx;
    logic [COORD_W-1:0] posy;
    logic [ID_W-1:0]    id;
  } sprite_attr_t;

  localparam sprite_attr_t RESET_ATTR = '{posx: '0, posy: '0, id: EMPTY_ID};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ctrl_state_e;

  // Number of entries whose ID is not the empty marker.
  function automatic logic [CNT_W-1:0] count_valid(input logic [NUM_SPRITES*ID_W-1:0] ids);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (ids[i*ID_W +: ID_W] != EMPTY_ID) n += CNT_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/sprite_table_if.sv
// Game-logic side bus of the sprite table: write port, control pulses, status and active buses.
interface sprite_table_if;
  import sprite_table_pkg::*;

  logic                           frame_start;
  logic                           wr_valid;
  logic                           wr_ready;
  logic [IDX_W-1:0]               wr_index;
  logic [COORD_W-1:0]             wr_posx;
  logic [COORD_W-1:0]             wr_posy;
  logic [ID_W-1:0]                wr_id;
  logic                           clear_req;
  logic                           commit_req;
  logic                           busy;
  logic                           commit_pending;
  logic                           commit_done;
  logic [CNT_W-1:0]               active_count;
  logic [NUM_SPRITES*COORD_W-1:0] posx_flat;
  logic [NUM_SPRITES*COORD_W-1:0] posy_flat;
  logic [NUM_SPRITES*ID_W-1:0]    id_flat;

  modport master (
    output frame_start, wr_valid, wr_index, wr_posx, wr_posy, wr_id, clear_req, commit_req,
    input  wr_ready, busy, commit_pending, commit_done, active_count, posx_flat, posy_flat, id_flat
  );

  modport slave (
    input  frame_start, wr_valid, wr_index, wr_posx, wr_posy, wr_id, clear_req, commit_req,
    output wr_ready, busy, commit_pending, commit_done, active_count, posx_flat, posy_flat, id_flat
  );

endinterface

// File: rtl/sprite_table_ctrl.sv
// Sequencing for the sprite table: shadow clear walk and frame-aligned commit bookkeeping.
module sprite_table_ctrl
  import sprite_table_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             frame_start_i,
  input  logic             clear_req_i,
  input  logic             commit_req_i,
  output logic             wr_ready_o,
  output logic             clr_we_o,
  output logic [IDX_W-1:0] clr_idx_o,
  output logic             commit_fire_o,
  output logic             busy_o,
  output logic             commit_pending_o,
  output logic             commit_done_o
);

  ctrl_state_e      state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             busy_q;
  logic             pending_q;
  logic             done_q;

  // A commit never overlaps a clear, so the copy always sees a consistent shadow.
  assign commit_fire_o = frame_start_i & (state_q == ST_IDLE) & (pending_q | commit_req_i);
  assign wr_ready_o    = (state_q == ST_IDLE) & ~clear_req_i;
  assign clr_we_o      = (state_q == ST_CLEAR);
  assign clr_idx_o     = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= commit_fire_o;
      if (commit_fire_o) begin
        pending_q <= 1'b0;
      end else if (commit_req_i) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (clear_req_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(NUM_SPRITES - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign commit_pending_o = pending_q;
  assign commit_done_o    = done_q;

endmodule

// File: rtl/sprite_table.sv
// Double-buffered sprite attribute table: writes land in shadow, shadow is copied to active on a frame boundary.
module sprite_table
  import sprite_table_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  sprite_table_if.slave bus
);

  sprite_attr_t shadow_q [NUM_SPRITES];
  sprite_attr_t shadow_d [NUM_SPRITES];
  sprite_attr_t active_q [NUM_SPRITES];
  logic [CNT_W-1:0] active_count_q;

  logic             wr_ready;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;
  logic             commit_fire;
  logic             wr_accept;

  logic [NUM_SPRITES*ID_W-1:0]    shadow_ids;
  logic [NUM_SPRITES*COORD_W-1:0] posx_flat;
  logic [NUM_SPRITES*COORD_W-1:0] posy_flat;
  logic [NUM_SPRITES*ID_W-1:0]    id_flat;

  sprite_table_ctrl u_ctrl (
    .clk_i            (Clk),
    .rst_ni           (Reset_n),
    .frame_start_i    (bus.frame_start),
    .clear_req_i      (bus.clear_req),
    .commit_req_i     (bus.commit_req),
    .wr_ready_o       (wr_ready),
    .clr_we_o         (clr_we),
    .clr_idx_o        (clr_idx),
    .commit_fire_o    (commit_fire),
    .busy_o           (bus.busy),
    .commit_pending_o (bus.commit_pending),
    .commit_done_o    (bus.commit_done)
  );

  assign wr_accept    = bus.wr_valid & wr_ready;
  assign bus.wr_ready = wr_ready;

  always_comb begin
    shadow_d = shadow_q;
    if (clr_we) shadow_d[clr_idx].id = EMPTY_ID;
    if (wr_accept) begin
      shadow_d[bus.wr_index] = '{posx: bus.wr_posx, posy: bus.wr_posy, id: bus.wr_id};
    end
  end

  always_comb begin
    shadow_ids = '0;
    for (int i = 0; i < NUM_SPRITES; i++) shadow_ids[i*ID_W +: ID_W] = shadow_q[i].id;
  end

  // Active copies the pre-edge shadow, so a same-cycle write only reaches the next frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= RESET_ATTR;
        active_q[i] <= RESET_ATTR;
      end
      active_count_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (commit_fire) begin
        active_q       <= shadow_q;
        active_count_q <= count_valid(shadow_ids);
      end
    end
  end

  always_comb begin
    posx_flat = '0;
    posy_flat = '0;
    id_flat   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      posx_flat[i*COORD_W +: COORD_W] = active_q[i].posx;
      posy_flat[i*COORD_W +: COORD_W] = active_q[i].posy;
      id_flat[i*ID_W +: ID_W]         = active_q[i].id;
    end
  end

  assign bus.posx_flat    = posx_flat;
  assign bus.posy_flat    = posy_flat;
  assign bus.id_flat      = id_flat;
  assign bus.active_count = active_count_q;

endmodule

// File: tb/tb_sprite_table.sv
// Bench for sprite_table: directed scenarios with literal expectations plus random traffic against a table model.
module tb_sprite_table;

  logic Clk;
  logic Reset_n;
  sprite_table_if bus ();

  sprite_table dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Model state: shadow and active tables, pending flag, remaining clear cycles.
  logic [9:0] m_sx [16];
  logic [9:0] m_sy [16];
  logic [3:0] m_sid[16];
  logic [9:0] m_ax [16];
  logic [9:0] m_ay [16];
  logic [3:0] m_aid[16];
  int         m_cnt;
  bit         m_pend;
  bit         m_done;
  int         m_clr_left;
  bit         m_ready;
  bit         m_fire;
  int         m_n;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        m_sx[i] = '0; m_sy[i] = '0; m_sid[i] = 4'hF;
        m_ax[i] = '0; m_ay[i] = '0; m_aid[i] = 4'hF;
      end
      m_cnt = 0; m_pend = 0; m_done = 0; m_clr_left = 0;
    end else begin
      m_ready = (m_clr_left == 0) && !bus.clear_req;
      m_fire  = bus.frame_start && (m_clr_left == 0) && (m_pend || bus.commit_req);
      m_done  = m_fire;
      if (m_fire) begin
        m_n = 0;
        for (int i = 0; i < 16; i++) begin
          m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_aid[i] = m_sid[i];
          if (m_sid[i] != 4'hF) m_n++;
        end
        m_cnt  = m_n;
        m_pend = 0;
      end else if (bus.commit_req) begin
        m_pend = 1;
      end
      if (m_clr_left > 0) begin
        m_sid[16 - m_clr_left] = 4'hF;
        m_clr_left--;
      end else if (bus.clear_req) begin
        m_clr_left = 16;
      end
      if (bus.wr_valid && m_ready) begin
        m_sx[bus.wr_index]  = bus.wr_posx;
        m_sy[bus.wr_index]  = bus.wr_posy;
        m_sid[bus.wr_index] = bus.wr_id;
      end
    end
  end

  logic [159:0] e_x, e_y;
  logic [63:0]  e_id;
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 16; i++) begin
        e_x[i*10 +: 10] = m_ax[i];
        e_y[i*10 +: 10] = m_ay[i];
        e_id[i*4 +: 4]  = m_aid[i];
      end
      chk("m_posx", bus.posx_flat, e_x);
      chk("m_posy", bus.posy_flat, e_y);
      chk("m_id", 160'(bus.id_flat), 160'(e_id));
      chk("m_count", 160'(bus.active_count), 160'(m_cnt));
      chk("m_pending", 160'(bus.commit_pending), 160'(m_pend));
      chk("m_done", 160'(bus.commit_done), 160'(m_done));
      chk("m_busy", 160'(bus.busy), 160'(m_clr_left > 0));
      chk("m_wr_ready", 160'(bus.wr_ready), 160'((m_clr_left == 0) && !bus.clear_req));
    end
  end

  task automatic idle();
    bus.frame_start = 0; bus.wr_valid = 0; bus.clear_req = 0; bus.commit_req = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic wr(input int idx, input int x, input int y, input int id);
    bus.wr_valid = 1;
    bus.wr_index = 4'(idx);
    bus.wr_posx  = 10'(x);
    bus.wr_posy  = 10'(y);
    bus.wr_id    = 4'(id);
  endtask

  logic [63:0] all_empty;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    all_empty = {16{4'hF}};
    Reset_n = 0;
    idle();
    bus.wr_index = '0; bus.wr_posx = '0; bus.wr_posy = '0; bus.wr_id = '0;
    repeat (3) @(posedge Clk);
    #2 Reset_n = 1;
    chk_en = 1;
    #1;
    // T1
    chk("t1_id", 160'(bus.id_flat), 160'(all_empty));
    chk("t1_count", 160'(bus.active_count), 160'd0);
    chk("t1_busy", 160'(bus.busy), 160'd0);
    chk("t1_wr_ready", 160'(bus.wr_ready), 160'd1);
    // T2
    wr(3, 100, 50, 2); bus.commit_req = 1;
    step(); idle();
    repeat (20) step();
    chk("t2_hold_id", 160'(bus.id_flat), 160'(all_empty));
    chk("t2_pending", 160'(bus.commit_pending), 160'd1);
    bus.frame_start = 1;
    step(); idle();
    chk("t2_posx3", 160'(bus.posx_flat[30 +: 10]), 160'd100);
    chk("t2_posy3", 160'(bus.posy_flat[30 +: 10]), 160'd50);
    chk("t2_id3", 160'(bus.id_flat[12 +: 4]), 160'd2);
    chk("t2_done", 160'(bus.commit_done), 160'd1);
    chk("t2_count", 160'(bus.active_count), 160'd1);
    step();
    chk("t2_done_low", 160'(bus.commit_done), 160'd0);
    // T3
    bus.commit_req = 1; bus.frame_start = 1; wr(5, 7, 9, 7);
    step(); idle();
    chk("t3_id5_empty", 160'(bus.id_flat[20 +: 4]), 160'hF);
    chk("t3_pending0", 160'(bus.commit_pending), 160'd0);
    bus.commit_req = 1; step(); idle();
    bus.frame_start = 1; step(); idle();
    chk("t3_id5", 160'(bus.id_flat[20 +: 4]), 160'd7);
    chk("t3_count", 160'(bus.active_count), 160'd2);
    // T4
    for (int i = 0; i < 16; i++) begin
      wr(i, i * 7, i * 3, (i == 15) ? 3 : i);
      step();
    end
    idle();
    bus.commit_req = 1; bus.frame_start = 1; step(); idle();
    chk("t4_count16", 160'(bus.active_count), 160'd16);
    bus.clear_req = 1; step(); idle();
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("t4_busy", 160'(bus.busy), 160'd1);
      chk("t4_wr_ready", 160'(bus.wr_ready), 160'd0);
      if (k == 8) begin bus.commit_req = 1; bus.frame_start = 1; end
      step(); idle();
      if (k == 8) begin
        chk("t4_no_copy", 160'(bus.active_count), 160'd16);
        chk("t4_no_done", 160'(bus.commit_done), 160'd0);
      end
    end
    chk("t4_busy_end", 160'(bus.busy), 160'd0);
    chk("t4_pending", 160'(bus.commit_pending), 160'd1);
    bus.frame_start = 1; step(); idle();
    chk("t4_count0", 160'(bus.active_count), 160'd0);
    chk("t4_id_empty", 160'(bus.id_flat), 160'(all_empty));
    // T5
    wr(0, 1, 1, 1); step(); idle();
    bus.commit_req = 1; bus.frame_start = 1; step(); idle();
    chk("t5_pre_count", 160'(bus.active_count), 160'd1);
    bus.commit_req = 1; step(); idle();
    bus.clear_req = 1; step(); idle();
    repeat (3) step();
    Reset_n = 0;
    #1;
    chk("t5_busy", 160'(bus.busy), 160'd0);
    chk("t5_pending", 160'(bus.commit_pending), 160'd0);
    chk("t5_id", 160'(bus.id_flat), 160'(all_empty));
    chk("t5_count", 160'(bus.active_count), 160'd0);
    step();
    Reset_n = 1;
    // T6
    wr(2, 11, 22, 9); step(); idle();
    bus.commit_req = 1; bus.frame_start = 1; step(); idle();
    chk("t6_done", 160'(bus.commit_done), 160'd1);
    chk("t6_pending", 160'(bus.commit_pending), 160'd0);
    chk("t6_id2", 160'(bus.id_flat[8 +: 4]), 160'd9);
    chk("t6_count", 160'(bus.active_count), 160'd1);
    // Random traffic, checked against the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 15), $urandom_range(0, 1023),
                                         $urandom_range(0, 1023), $urandom_range(0, 15));
      bus.clear_req   = ($urandom_range(0, 39) == 0);
      bus.commit_req  = ($urandom_range(0, 9) == 0);
      bus.frame_start = ($urandom_range(0, 11) == 0);
      step();
    end
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
